// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider: one quotient bit per clock on operand magnitudes, then sign fix-up.
// Latency: done WIDTH+4 cycles after start (3 cycles for divide-by-zero); results packed {remainder, quotient}.
// Backpressure: none; start is sampled only in IDLE and ignored while busy, outputs hold until the next result.
module seq_signed_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_DVSR, CHECK, ITER, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   a_reg;     // partial remainder, one bit wider than the operands
  logic [WIDTH-1:0] q_reg;     // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] m_reg;     // divisor magnitude
  logic [WIDTH-1:0] dvnd;      // original dividend, kept for the divide-by-zero remainder and overflow test
  logic             sgn_q;
  logic             sgn_r;
  logic             dvsr_m1;   // divisor was -1
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] din_mag;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   diff;

  // Magnitude is taken as an unsigned value so the most-negative operand stays exact.
  assign din_mag = data_in[WIDTH-1] ? -data_in : data_in;
  // Shift {A,Q} left by one and trial-subtract the divisor; diff MSB set means the subtraction went negative.
  assign a_sh    = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign diff    = a_sh - {1'b0, m_reg};
  assign result  = {remainder, quotient};

  // Control FSM plus datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      dvnd      <= '0;
      sgn_q     <= 1'b0;
      sgn_r     <= 1'b0;
      dvsr_m1   <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvnd  <= data_in;
            q_reg <= din_mag;
            sgn_q <= data_in[WIDTH-1];
            sgn_r <= data_in[WIDTH-1];
            busy  <= 1'b1;
            state <= LOAD_DVSR;
          end
        end
        LOAD_DVSR: begin
          m_reg   <= din_mag;
          sgn_q   <= sgn_q ^ data_in[WIDTH-1];
          dvsr_m1 <= (data_in == '1);
          state   <= CHECK;
        end
        CHECK: begin
          if (m_reg == '0) begin
            quotient  <= '1;
            remainder <= dvnd;
            dbz       <= 1'b1;
            ovf       <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            a_reg <= '0;
            cnt   <= CW'(WIDTH);
            state <= ITER;
          end
        end
        ITER: begin
          q_reg <= {q_reg[WIDTH-2:0], ~diff[WIDTH]};
          a_reg <= diff[WIDTH] ? a_sh : diff;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          // The overflow case wraps naturally: magnitude 2^(WIDTH-1) with a positive sign reads back as MOST_NEG.
          quotient  <= sgn_q ? -q_reg : q_reg;
          remainder <= sgn_r ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
          dbz       <= 1'b0;
          ovf       <= (dvnd == MOST_NEG) && dvsr_m1;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
